sw_alloc_3port: RTL and testbench

//  Packet-level round-robin switch allocator for the 3-port router.
//  - Each input presents its route-compute result (one-hot output port) per head flit.
//  - Each output is granted to at most one input; the grant is held until that

---
 rtl/sw_alloc_3port.sv | 172 +++++++++++++++++
 tb/tb_sw_alloc_3port.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_alloc_3port.sv
// Packet-level round-robin switch allocator for a 3-input / 3-output router.
// Each output is owned by one input from its head flit until its tail flit transfers.
module sw_alloc_3port #(
    parameter int unsigned PTR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] in_valid,
    input  logic [8:0] in_port,
    input  logic [2:0] in_tail,
    input  logic [2:0] out_ready,
    output logic [2:0] in_ready,
    output logic [2:0] out_valid,
    output logic [5:0] out_sel,
    output logic [8:0] grant,
    output logic       bad_req
);

    localparam logic [1:0] PTR_RST  = 2'(PTR_INIT);
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e     state_q [3];
    state_e     state_d [3];
    logic [1:0] ptr_q   [3];
    logic [1:0] ptr_d   [3];
    logic [8:0] grant_q;
    logic [8:0] grant_d;
    logic [5:0] out_sel_q;
    logic [5:0] out_sel_d;
    logic       bad_req_q;
    logic       bad_req_d;

    logic [2:0] locked_s;
    logic [2:0] illegal_s;
    logic [2:0] req_s       [3];
    logic [2:0] pick_s      [3];
    logic [2:0] tail_xfer_s;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end else begin
            sum = sum;
        end
        return sum[1:0];
    endfunction

    function automatic logic is_onehot3(input logic [2:0] code);
        return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
    endfunction

    // {found, index} of the first requester at or after ptr, wrapping mod 3
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            cand = mod3_add(ptr, 2'(k));
            if (req[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Request qualification: lock state, legal codes, idle outputs, owner tail transfers
    always_comb begin
        locked_s    = 3'b000;
        illegal_s   = 3'b000;
        tail_xfer_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            locked_s[i]  = grant_q[i] | grant_q[3 + i] | grant_q[6 + i];
            illegal_s[i] = in_valid[i] & ~locked_s[i] & (in_port[3*i +: 3] != 3'b000)
                         & ~is_onehot3(in_port[3*i +: 3]);
        end
        for (int o = 0; o < 3; o++) begin
            req_s[o] = 3'b000;
            for (int i = 0; i < 3; i++) begin
                req_s[o][i] = in_valid[i] & ~locked_s[i] & (state_q[o] == ST_IDLE)
                            & (in_port[3*i +: 3] == (3'b001 << o));
                tail_xfer_s[o] = tail_xfer_s[o]
                               | (grant_q[3*o + i] & in_valid[i] & out_ready[o] & in_tail[i]);
            end
            pick_s[o] = rr_pick(req_s[o], ptr_q[o]);
        end
    end

    // Next-state: per-output IDLE/BUSY transitions, grant/select/pointer updates
    always_comb begin
        grant_d   = grant_q;
        out_sel_d = out_sel_q;
        bad_req_d = bad_req_q | (|illegal_s);
        for (int o = 0; o < 3; o++) begin
            state_d[o] = state_q[o];
            ptr_d[o]   = ptr_q[o];
            case (state_q[o])
                ST_IDLE: begin
                    if (en && pick_s[o][2]) begin
                        state_d[o]                      = ST_BUSY;
                        grant_d[3*o + int'(pick_s[o][1:0])] = 1'b1;
                        out_sel_d[2*o +: 2]             = pick_s[o][1:0];
                    end else begin
                        state_d[o] = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (tail_xfer_s[o]) begin
                        state_d[o]          = ST_IDLE;
                        grant_d[3*o +: 3]   = 3'b000;
                        out_sel_d[2*o +: 2] = SEL_NONE;
                        ptr_d[o]            = mod3_add(out_sel_q[2*o +: 2], 2'd1);
                    end else begin
                        state_d[o] = ST_BUSY;
                    end
                end
                default: begin
                    state_d[o]          = ST_IDLE;
                    grant_d[3*o +: 3]   = 3'b000;
                    out_sel_d[2*o +: 2] = SEL_NONE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= 9'b0_0000_0000;
            out_sel_q <= 6'b11_1111;
            bad_req_q <= 1'b0;
            for (int o = 0; o < 3; o++) begin
                state_q[o] <= ST_IDLE;
                ptr_q[o]   <= PTR_RST;
            end
        end else begin
            grant_q   <= grant_d;
            out_sel_q <= out_sel_d;
            bad_req_q <= bad_req_d;
            for (int o = 0; o < 3; o++) begin
                state_q[o] <= state_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    // Flit handshakes follow the current grants combinationally
    always_comb begin
        in_ready  = 3'b000;
        out_valid = 3'b000;
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++) begin
                in_ready[i]  = in_ready[i]  | (grant_q[3*o + i] & out_ready[o]);
                out_valid[o] = out_valid[o] | (grant_q[3*o + i] & in_valid[i]);
            end
        end
    end

    assign grant   = grant_q;
    assign out_sel = out_sel_q;
    assign bad_req = bad_req_q;

endmodule

// File: tb/tb_sw_alloc_3port.sv
// Bench for sw_alloc_3port: fixed vectors, directed packet sequences and random
// traffic compared against a packet-level ownership model.
module tb_sw_alloc_3port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] in_valid;
    logic [8:0] in_port;
    logic [2:0] in_tail;
    logic [2:0] out_ready;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [5:0] out_sel;
    logic [8:0] grant;
    logic       bad_req;

    int checks = 0;
    int errors = 0;

    sw_alloc_3port #(.PTR_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_port(in_port),
        .in_tail(in_tail), .out_ready(out_ready), .in_ready(in_ready),
        .out_valid(out_valid), .out_sel(out_sel), .grant(grant), .bad_req(bad_req)
    );

    always #5 clk = ~clk;

    // Reference model: which input owns each output (-1 = free), rr pointer, error flag
    int m_owner[3];
    int m_ptr[3];
    bit m_bad;

    // Snapshot of DUT outputs from the latest step
    logic [8:0] snap_g;
    logic [5:0] snap_s;
    logic [2:0] snap_ir;
    logic [2:0] snap_ov;

    // Per-input packet sources for directed sequences
    int         rem[3];
    logic [2:0] dst[3];

    typedef struct {
        logic       en;
        logic [2:0] v;
        logic [8:0] port;
        logic [2:0] tail;
        logic [2:0] ordy;
        logic [8:0] g;
        logic [5:0] sel;
        logic [2:0] irdy;
        logic [2:0] ovld;
        logic       bad;
    } vec_t;

    vec_t tbl[9];
    int   lg[$];
    int   exp_lg[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] port_of(input int i);
        return in_port[3*i +: 3];
    endfunction

    function automatic void model_reset();
        for (int o = 0; o < 3; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
        end
        m_bad = 1'b0;
    endfunction

    function automatic void model_expect(output logic [8:0] g, output logic [5:0] s,
                                         output logic [2:0] ir, output logic [2:0] ov);
        g = '0; s = 6'h3f; ir = '0; ov = '0;
        for (int o = 0; o < 3; o++) begin
            if (m_owner[o] >= 0) begin
                g[3*o + m_owner[o]] = 1'b1;
                s[2*o +: 2] = 2'(m_owner[o]);
                if (out_ready[o]) ir[m_owner[o]] = 1'b1;
                if (in_valid[m_owner[o]]) ov[o] = 1'b1;
            end
        end
    endfunction

    function automatic void model_clock();
        int nxt[3];
        bit locked[3];
        for (int i = 0; i < 3; i++) locked[i] = 1'b0;
        for (int o = 0; o < 3; o++) if (m_owner[o] >= 0) locked[m_owner[o]] = 1'b1;
        for (int i = 0; i < 3; i++)
            if (in_valid[i] && !locked[i] && $countones(port_of(i)) > 1) m_bad = 1'b1;
        for (int o = 0; o < 3; o++) begin
            nxt[o] = m_owner[o];
            if (m_owner[o] >= 0) begin
                if (in_valid[m_owner[o]] && out_ready[o] && in_tail[m_owner[o]]) begin
                    nxt[o]   = -1;
                    m_ptr[o] = (m_owner[o] + 1) % 3;
                end
            end else if (en) begin
                for (int k = 0; k < 3; k++) begin
                    int c;
                    c = (m_ptr[o] + k) % 3;
                    if (nxt[o] < 0 && in_valid[c] && !locked[c] && port_of(c) == 3'(1 << o))
                        nxt[o] = c;
                end
            end
        end
        for (int o = 0; o < 3; o++) m_owner[o] = nxt[o];
    endfunction

    // Called just after a falling edge with inputs already driven
    task automatic step();
        logic [8:0] eg;
        logic [5:0] es;
        logic [2:0] eir, eov;
        #1;
        model_expect(eg, es, eir, eov);
        snap_g = grant; snap_s = out_sel; snap_ir = in_ready; snap_ov = out_valid;
        chk("grant", grant, eg);
        chk("out_sel", out_sel, es);
        chk("in_ready", in_ready, eir);
        chk("out_valid", out_valid, eov);
        chk("bad_req", bad_req, m_bad);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b1; in_valid = '0; in_port = '0; in_tail = '0; out_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0;
            dst[i] = 3'b000;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_src();
        for (int i = 0; i < 3; i++) begin
            in_valid[i]       = (rem[i] > 0);
            in_port[3*i +: 3] = dst[i];
            in_tail[i]        = (rem[i] == 1);
        end
    endtask

    task automatic src_step();
        drive_src();
        step();
        for (int i = 0; i < 3; i++) if (snap_ir[i] && in_valid[i]) rem[i]--;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 3'b001, 9'b000_000_010, 3'b001, 3'b111, 9'b0,           6'b111111, 3'b000, 3'b000, 1'b0};
        tbl[1] = '{1'b1, 3'b001, 9'b000_000_010, 3'b001, 3'b111, 9'b000_001_000, 6'b110011, 3'b001, 3'b010, 1'b0};
        tbl[2] = '{1'b1, 3'b000, 9'b000_000_000, 3'b000, 3'b111, 9'b0,           6'b111111, 3'b000, 3'b000, 1'b0};
        tbl[3] = '{1'b1, 3'b110, 9'b100_010_000, 3'b110, 3'b111, 9'b0,           6'b111111, 3'b000, 3'b000, 1'b0};
        tbl[4] = '{1'b1, 3'b110, 9'b100_010_000, 3'b110, 3'b111, 9'b100_010_000, 6'b100111, 3'b110, 3'b110, 1'b0};
        tbl[5] = '{1'b1, 3'b000, 9'b000_000_000, 3'b000, 3'b111, 9'b0,           6'b111111, 3'b000, 3'b000, 1'b0};
        tbl[6] = '{1'b1, 3'b001, 9'b000_000_011, 3'b001, 3'b111, 9'b0,           6'b111111, 3'b000, 3'b000, 1'b0};
        tbl[7] = '{1'b1, 3'b001, 9'b000_000_011, 3'b001, 3'b111, 9'b0,           6'b111111, 3'b000, 3'b000, 1'b1};
        tbl[8] = '{1'b1, 3'b000, 9'b000_000_000, 3'b000, 3'b111, 9'b0,           6'b111111, 3'b000, 3'b000, 1'b1};
        exp_lg = '{-1, 0, 0, 0, -1, 1, 1, 1, -1, 2, 2, 2};

        // Fixed vectors: single-flit X1 packet, concurrent X1/Y1, illegal code
        do_reset();
        for (int r = 0; r < 9; r++) begin
            en = tbl[r].en; in_valid = tbl[r].v; in_port = tbl[r].port;
            in_tail = tbl[r].tail; out_ready = tbl[r].ordy;
            #1;
            chk("tbl_grant", grant, tbl[r].g);
            chk("tbl_out_sel", out_sel, tbl[r].sel);
            chk("tbl_in_ready", in_ready, tbl[r].irdy);
            chk("tbl_out_valid", out_valid, tbl[r].ovld);
            chk("tbl_bad_req", bad_req, tbl[r].bad);
            @(negedge clk);
        end

        // Three 3-flit packets contending for LOCAL: order 0,1,2 with one-cycle gaps
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rem[i] = 3;
            dst[i] = 3'b001;
        end
        for (int c = 0; c < 40 && (rem[0] + rem[1] + rem[2]) > 0; c++) begin
            src_step();
            lg.push_back((snap_ov[0] && out_ready[0]) ? int'(snap_s[1:0]) : -1);
        end
        chk("t2_len", lg.size(), 12);
        for (int i = 0; i < 12 && i < lg.size(); i++) chk("t2_order", lg[i], exp_lg[i]);

        // Y1 stall mid-packet with in_port changed: grant held, nothing lost
        do_reset();
        rem[1] = 4;
        dst[1] = 3'b100;
        repeat (3) src_step();
        out_ready = 3'b011;
        dst[1] = 3'b001;
        repeat (5) begin
            src_step();
            chk("t4_hold", snap_g[7], 1'b1);
            chk("t4_stall_rdy", snap_ir[1], 1'b0);
        end
        out_ready = 3'b111;
        for (int c = 0; c < 10 && rem[1] > 0; c++) src_step();
        chk("t4_all_flits", rem[1], 0);
        src_step();

        // en=0 freezes new grants while an X1 packet drains and releases
        do_reset();
        rem[2] = 3;
        dst[2] = 3'b010;
        src_step();
        en = 1'b0;
        rem[0] = 2;
        dst[0] = 3'b001;
        for (int c = 0; c < 10 && rem[2] > 0; c++) begin
            src_step();
            chk("t5_frozen", snap_g[0], 1'b0);
        end
        src_step();
        chk("t5_frozen", snap_g[0], 1'b0);
        chk("t5_x1_free", snap_g[5:3], 3'b000);
        en = 1'b1;
        src_step();
        src_step();
        chk("t5_grant", snap_g[0], 1'b1);
        for (int c = 0; c < 10 && rem[0] > 0; c++) src_step();
        chk("t5_drained", rem[0], 0);

        // Asynchronous reset mid-packet clears everything at once
        do_reset();
        rem[0] = 3;
        dst[0] = 3'b001;
        src_step();
        src_step();
        drive_src();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_grant", grant, 9'b0);
        chk("t6_out_sel", out_sel, 6'b111111);
        chk("t6_in_ready", in_ready, 3'b000);
        chk("t6_out_valid", out_valid, 3'b000);
        chk("t6_bad_req", bad_req, 1'b0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int r;
            en        = ($urandom_range(0, 9) != 0);
            out_ready = 3'($urandom);
            in_valid  = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                r = $urandom_range(0, 15);
                if (r < 4)       in_port[3*i +: 3] = 3'b001;
                else if (r < 8)  in_port[3*i +: 3] = 3'b010;
                else if (r < 12) in_port[3*i +: 3] = 3'b100;
                else if (r < 15) in_port[3*i +: 3] = 3'b000;
                else             in_port[3*i +: 3] = 3'($urandom_range(3, 7));
                in_tail[i] = ($urandom_range(0, 2) == 0);
            end
            if (c < 300 && $countones(in_port[2:0]) > 1) in_port[2:0] = 3'b000;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
